stream_fifo: RTL

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/cmn_pkg.sv | 18 +
 rtl/stream_fifo_mem.sv | 29 ++
 rtl/stream_fifo.sv | 112 +++++++++++
 3 files changed

// File: rtl/cmn_pkg.sv
// Shared defaults for the common FIFO family: default data width, default
// depth, a pointer/occupancy typedef sized for the default depth, and a
// helper that returns the pointer width for any depth.
package cmn_pkg;

  localparam int CMN_DATA_W     = 8;
  localparam int CMN_FIFO_DEPTH = 8;

  // Occupancy/pointer type for the default depth: one extra bit beyond the
  // address so that "full" and "empty" can be told apart.
  typedef logic [$clog2(CMN_FIFO_DEPTH):0] ptr_t;

  // Pointer width (address bits plus one wrap bit) for an arbitrary depth.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Storage array for stream_fifo: DEPTH x DATA_W, one synchronous write port
// and one asynchronous read port. The array has no reset; the FIFO control
// logic never presents a word whose slot has not been written.
module stream_fifo_mem
  import cmn_pkg::*;
#(
  parameter int DATA_W = CMN_DATA_W,
  parameter int DEPTH  = CMN_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_wrEn,
  input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
  input  logic [DATA_W-1:0]        i_wrData,
  input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
  output logic [DATA_W-1:0]        o_rdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write the incoming word into its slot on an accepted push.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready stream FIFO with show-ahead output, occupancy
// count and almost_full flag. Storage lives in stream_fifo_mem; pointer,
// count, flag and error logic live here.
// Optional feature: define CMN_FIFO_ERR_EN to add the sticky 'err' output,
// which flags an upstream that withdraws or changes a stalled word.
module stream_fifo
  import cmn_pkg::*;
#(
  parameter int DATA_W    = CMN_DATA_W,
  parameter int DEPTH     = CMN_FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full
`ifdef CMN_FIFO_ERR_EN
  ,
  output logic                   err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptrWidth(DEPTH);
  localparam logic [PW-1:0] AF_COUNT = PW'(AF_THRESH);

  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Full when the wrap bits differ but the slot addresses match; empty when
  // the pointers are identical. Pointers wrap modulo 2*DEPTH naturally.
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_count = r_wrPtr - r_rdPtr;

  // Ready depends only on our own state, never on out_ready, so there is no
  // combinational path from downstream back to upstream. A full FIFO that is
  // being popped still refuses the push that cycle.
  assign in_ready    = !w_full;
  assign out_valid   = !w_empty;
  assign w_push      = in_valid && in_ready;
  assign w_pop       = out_valid && out_ready;
  assign count       = w_count;
  assign almost_full = (w_count >= AF_COUNT);

  // Advance each pointer on its own handshake; reset discards all contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  stream_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_wrEn  (w_push),
    .i_wrAddr(r_wrPtr[AW-1:0]),
    .i_wrData(in_data),
    .i_rdAddr(r_rdPtr[AW-1:0]),
    .o_rdData(out_data)
  );

`ifdef CMN_FIFO_ERR_EN
  logic              r_stalled;
  logic [DATA_W-1:0] r_stallData;
  logic              r_err;
  logic              w_violation;

  // A word offered but refused last cycle must be offered again unchanged;
  // dropping valid or altering the data before acceptance is a violation.
  assign w_violation = r_stalled && (!in_valid || (in_data != r_stallData));
  assign err         = r_err;

  // Remember any refused offer and latch a violation until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stalled   <= 1'b0;
      r_stallData <= '0;
      r_err       <= 1'b0;
    end else begin
      r_stalled   <= in_valid && !in_ready;
      r_stallData <= in_data;
      if (w_violation) begin
        r_err <= 1'b1;
      end
    end
  end
`endif

endmodule
